// File: rtl/midi_fifo.sv
// Single-clock MIDI byte FIFO with registered read data, occupancy level,
// full/empty/almost-full flags, sticky overflow/underflow and synchronous flush.
module midi_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO_L  = (ADDR_WIDTH+1)'(0);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic [ADDR_WIDTH:0]   level_nxt_s;

  // Acceptance decisions and next occupancy; flags are derived from level_nxt_s
  // so they land in the same cycle as level.
  always_comb begin
    rd_acc_s    = re && !empty;
    wr_acc_s    = we && (!full || rd_acc_s);
    level_nxt_s = level;
    if (wr_acc_s && !rd_acc_s) begin
      level_nxt_s = level + ONE_L;
    end else if (rd_acc_s && !wr_acc_s) begin
      level_nxt_s = level - ONE_L;
    end else begin
      level_nxt_s = level;
    end
  end

  // Storage array: no reset, flush leaves contents in place; read-first via NBA.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst && !flush) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  // Pointers, read port, level, flags; rst beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= ZERO_L;
      rd_ptr_r    <= ZERO_L;
      rdata       <= {DATA_WIDTH{1'b0}};
      rvalid      <= 1'b0;
      level       <= ZERO_L;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= ZERO_L;
      rd_ptr_r    <= ZERO_L;
      rvalid      <= 1'b0;
      level       <= ZERO_L;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_L;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_L;
        rdata    <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
        rvalid   <= 1'b1;
      end else begin
        rvalid   <= 1'b0;
      end
      level       <= level_nxt_s;
      full        <= (level_nxt_s == DEPTH_L);
      empty       <= (level_nxt_s == ZERO_L);
      almost_full <= (level_nxt_s >= AF_L);
      if (we && !wr_acc_s) begin
        overflow <= 1'b1;
      end
      if (re && !rd_acc_s) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_midi_fifo.sv
// Directed self-checking bench for midi_fifo (default parameters, depth 512).
module tb_midi_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, we, re;
  logic [7:0] wdata, rdata;
  logic       rvalid, full, empty, almost_full, overflow, underflow;
  logic [9:0] level;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];

  midi_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .level(level), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    we = 1'b1; re = 1'b0; wdata = d;
    tick();
    we = 1'b0;
    q.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    re = 1'b1; we = 1'b0;
    tick();
    re = 1'b0;
    e = q.pop_front();
    check_val({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check_val({tag, "_rdata"}, 32'(rdata), 32'(e));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_rdata"}, 32'(rdata), 32'd0);
    check_val({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
    check_val({tag, "_af"}, 32'(almost_full), 32'd0);
    check_val({tag, "_level"}, 32'(level), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    // Reset with random traffic on the inputs
    rst = 1'b1; flush = 1'b0;
    we = 1'($urandom); re = 1'($urandom); wdata = 8'($urandom);
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b0; wdata = 8'h00;
    check_reset_state("reset");

    // Fill
    for (int i = 0; i < 512; i++) push(8'((i + 1) & 255));
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_level", 32'(level), 32'd512);
    check_val("fill_af", 32'(almost_full), 32'd1);
    check_val("fill_ovf", 32'(overflow), 32'd0);

    // Simultaneous read/write at full: oldest word out, AA accepted
    we = 1'b1; re = 1'b1; wdata = 8'hAA;
    tick();
    we = 1'b0; re = 1'b0;
    void'(q.pop_front());
    q.push_back(8'hAA);
    check_val("simul_rdata", 32'(rdata), 32'h01);
    check_val("simul_rvalid", 32'(rvalid), 32'd1);
    check_val("simul_level", 32'(level), 32'd512);
    check_val("simul_ovf", 32'(overflow), 32'd0);

    // Overflow at full
    we = 1'b1; wdata = 8'h55;
    tick();
    we = 1'b0;
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_level", 32'(level), 32'd512);
    check_val("ovf_full", 32'(full), 32'd1);

    // Drain: 2..255,0,1..255,0 then AA
    for (int k = 0; k < 512; k++) pop_chk("drain");
    check_val("drain_last", 32'(rdata), 32'hAA);
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_level", 32'(level), 32'd0);
    check_val("drain_unf", 32'(underflow), 32'd0);

    // Underflow on empty
    re = 1'b1;
    tick();
    re = 1'b0;
    check_val("unf_flag", 32'(underflow), 32'd1);
    check_val("unf_rvalid", 32'(rvalid), 32'd0);
    check_val("unf_level", 32'(level), 32'd0);

    // Flush clears sticky flags, rdata holds
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush1_ovf", 32'(overflow), 32'd0);
    check_val("flush1_unf", 32'(underflow), 32'd0);
    check_val("flush1_empty", 32'(empty), 32'd1);
    check_val("flush1_rdata", 32'(rdata), 32'hAA);

    // Wrap-around: push 300, pop 300, push 300 then climb to threshold
    for (int p = 0; p < 300; p++) push(8'((p * 3) & 255));
    for (int p = 0; p < 300; p++) pop_chk("wrap_a");
    for (int p = 0; p < 495; p++) push(8'((p * 7 + 5) & 255));
    check_val("af_495_level", 32'(level), 32'd495);
    check_val("af_495_flag", 32'(almost_full), 32'd0);
    push(8'h5A);
    check_val("af_496_level", 32'(level), 32'd496);
    check_val("af_496_flag", 32'(almost_full), 32'd1);
    pop_chk("af_pop");
    check_val("af_back_level", 32'(level), 32'd495);
    check_val("af_back_flag", 32'(almost_full), 32'd0);
    for (int p = 0; p < 495; p++) pop_chk("wrap_b");
    check_val("wrap_empty", 32'(empty), 32'd1);

    // Flush mid-burst at level 100
    for (int p = 0; p < 100; p++) push(8'(p + 16));
    for (int p = 0; p < 4; p++) begin
      we = 1'b1; re = 1'b1; wdata = 8'(8'hC0 + p);
      tick();
      q.push_back(8'(8'hC0 + p));
      check_val("burst_rdata", 32'(rdata), 32'(q.pop_front()));
      check_val("burst_level", 32'(level), 32'd100);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; we = 1'b0; re = 1'b0;
    q.delete();
    check_val("flush2_level", 32'(level), 32'd0);
    check_val("flush2_empty", 32'(empty), 32'd1);
    check_val("flush2_rvalid", 32'(rvalid), 32'd0);
    check_val("flush2_ovf", 32'(overflow), 32'd0);
    check_val("flush2_unf", 32'(underflow), 32'd0);
    push(8'h3C);
    check_val("post_flush_level", 32'(level), 32'd1);
    pop_chk("post_flush");

    // we and re together on empty: write wins, read rejected
    we = 1'b1; re = 1'b1; wdata = 8'h77;
    tick();
    we = 1'b0; re = 1'b0;
    check_val("empty_wr_level", 32'(level), 32'd1);
    check_val("empty_wr_unf", 32'(underflow), 32'd1);
    check_val("empty_wr_rvalid", 32'(rvalid), 32'd0);

    // Mid-operation reset discards data
    push(8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
